div_unit_ctrl: RTL and testbench
================================

Name: div_unit_ctrl

Overview:
- Sequencer for the iterative 32-bit divider serving RV32M DIV/DIVU/REM/REMU.
- Accepts one operation from EX and runs a radix-2 restoring divide, one quotient bit per cycle.
- Publishes busy/rd_addr status to hazard detection, honours WAW flush, and holds the result until the writeback arbiter grants the register-file write port.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
- i_clk  input  1  clock
- i_reset  input  1  asynchronous active-high reset
- i_start  input  1  valid DIV-class instruction in EX (div_en & valid); sampled on rising edge
- i_funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1_val  input  XLEN  dividend
- i_rs2_val  input  XLEN  divisor
- i_rd_addr  input  5  destination register
- i_flush  input  1  WAW flush from hazard detection; kills in-flight op
- o_busy  output  1  op in CALC or DONE
- o_rd_addr  output  5  rd of in-flight op; 5'b0 when not busy
- o_wb_req  output  1  result ready, requesting WB port
- o_wb_rd_addr  output  5  rd for writeback
- o_wb_data  output  XLEN  quotient or remainder
- i_wb_gnt  input  1  WB port granted this cycle

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, counter 0, internal operand regs 0.
- States:
  - IDLE -> CALC on i_start.
  - CALC -> DONE after iteration XLEN-1 (counter wraps 31->0).
  - DONE -> IDLE on i_wb_gnt.
  - CALC/DONE -> IDLE on i_flush.
- Start: latch rd, funct3, sign flags, |rs1|, |rs2| for signed ops (raw values for unsigned); remainder reg=0; counter=0. i_start while busy is ignored (hazard unit stalls it).
- CALC, each cycle:
  - remainder = {rem[XLEN-2:0], dividend MSB}; trial = remainder - divisor (XLEN+1 bits).
  - If trial non-negative, remainder=trial and quotient bit=1; else quotient bit=0.
  - Shift dividend/quotient left by 1.
- Normal latency: i_start at edge N -> o_wb_req high from after edge N+XLEN+1 (33 cycles for XLEN=32).
- Sign fixup on entry to DONE:
  - Quotient negated iff signed op and operand signs differ.
  - Remainder takes the dividend's sign.
- Special results, forced regardless of algorithm output:
  - Divisor 0: quotient = all ones, remainder = rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- o_wb_data = quotient for funct3[1]=0, remainder for funct3[1]=1.
- DONE:
  - o_wb_req, o_wb_rd_addr and o_wb_data held stable until i_wb_gnt.
  - Cycle after grant: IDLE, o_wb_req=0, o_busy=0.
- o_rd_addr forced to 0 whenever o_busy=0, so hazard comparisons against a stale rd cannot match.
- Flush:
  - In CALC or DONE: next cycle IDLE, no o_wb_req issued, o_busy=0.
  - In IDLE: no effect.
  - Same cycle as i_wb_gnt in DONE: the write completes (gnt honoured) and state goes to IDLE.
  - Same cycle as i_start in IDLE: start accepted.
- rd_addr=0 ops execute normally. The WB arbiter discards the write; the block does not special-case it.

Optional Feature:
- DIV_FAST_SPECIAL_EN
- Defined: divisor-0 and signed-overflow ops skip CALC. IDLE -> DONE directly, o_wb_req high after the next edge (latency 1).
- Undefined: these ops run the full XLEN-cycle CALC and produce identical forced results.
- Results are bit-identical either way; only latency differs.

Test Plan:
- DIVU 100/7, rd=5 -> o_busy=1 and o_rd_addr=5 for 33 cycles; o_wb_req with data 14, rd 5; gnt -> IDLE, o_rd_addr=0.
- REM -7 % 2 (0xFFFFFFF9, 2) -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. Latency 1 with DIV_FAST_SPECIAL_EN, 33 without.
- i_flush at cycle 10 of CALC -> o_busy=0 next cycle, o_wb_req never asserts; new i_start 2 cycles later completes correctly.
- DONE with i_wb_gnt held low 5 cycles -> o_wb_req/data/rd stable throughout; i_start during the wait ignored; gnt -> single write.
- i_reset pulsed asynchronously mid-CALC (between edges) -> outputs 0 immediately, state IDLE, next op correct.

Source files
------------

// File: rtl/div_unit_ctrl.sv
// div_unit_ctrl: radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FAST_SPECIAL_EN to retire divide-by-zero and signed-overflow ops without iterating.
module div_unit_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_busy,
  output logic [4:0]      o_rd_addr,
  output logic            o_wb_req,
  output logic [4:0]      o_wb_rd_addr,
  output logic [XLEN-1:0] o_wb_data,
  input  logic            i_wb_gnt
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        rd_q;
  logic              sel_rem_q, qneg_q, rneg_q, div0_q, ovf_q;
  logic [XLEN-1:0]   dvd_q, dvs_q, rem_q;
  logic              go, sgn, a_neg, b_neg, div0_d, ovf_d, skip_d, ge;
  logic [XLEN-1:0]   a_abs, b_abs, sh, rem_d, q_fix, r_fix;
  always_comb begin
    go     = i_start & i_funct3[2];
    sgn    = ~i_funct3[0];
    a_neg  = sgn & i_rs1_val[XLEN-1];
    b_neg  = sgn & i_rs2_val[XLEN-1];
    a_abs  = a_neg ? -i_rs1_val : i_rs1_val;
    b_abs  = b_neg ? -i_rs2_val : i_rs2_val;
    div0_d = i_rs2_val == '0;
    ovf_d  = sgn & (i_rs1_val == MIN) & (&i_rs2_val);
`ifdef DIV_FAST_SPECIAL_EN
    skip_d = div0_d | ovf_d;
`else
    skip_d = 1'b0;
`endif
    // a set remainder MSB means the shifted value already exceeds any XLEN-bit divisor
    sh     = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
    ge     = rem_q[XLEN-1] | (sh >= dvs_q);
    rem_d  = ge ? sh - dvs_q : sh;
    q_fix  = div0_q ? '1 : ovf_q ? MIN : qneg_q ? -dvd_q : dvd_q;
    r_fix  = ovf_q ? '0 : rneg_q ? -rem_q : rem_q;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_q         <= '0;
      sel_rem_q    <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      div0_q       <= 1'b0;
      ovf_q        <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      o_wb_req     <= 1'b0;
      o_wb_rd_addr <= '0;
      o_wb_data    <= '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          state_q   <= skip_d ? DONE : CALC;
          cnt_q     <= '0;
          rd_q      <= i_rd_addr;
          sel_rem_q <= i_funct3[1];
          qneg_q    <= a_neg ^ b_neg;
          rneg_q    <= a_neg;
          div0_q    <= div0_d;
          ovf_q     <= ovf_d;
          dvd_q     <= a_abs;
          dvs_q     <= b_abs;
          // the skipped divide-by-zero path still needs |rs1| as its remainder
          rem_q     <= (skip_d & div0_d) ? a_abs : '0;
        end
        CALC: if (i_flush) state_q <= IDLE;
        else begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[XLEN-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= DONE;
        end
        DONE: if ((o_wb_req & i_wb_gnt) | i_flush) begin
          state_q  <= IDLE;
          o_wb_req <= 1'b0;
        end else if (!o_wb_req) begin
          o_wb_req     <= 1'b1;
          o_wb_rd_addr <= rd_q;
          o_wb_data    <= sel_rem_q ? r_fix : q_fix;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_busy    = state_q != IDLE;
  assign o_rd_addr = o_busy ? rd_q : 5'd0;
endmodule

// File: tb/tb_div_unit_ctrl.sv
// tb_div_unit_ctrl: directed and randomized checks of div_unit_ctrl against a cycle-level reference model.
module tb_div_unit_ctrl;
`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int SL = FAST ? 1 : 33;
  logic        i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_flush = 1'b0, i_wb_gnt = 1'b0;
  logic [2:0]  i_funct3 = 3'd4;
  logic [31:0] i_rs1_val = '0, i_rs2_val = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        o_busy, o_wb_req;
  logic [4:0]  o_rd_addr, o_wb_rd_addr;
  logic [31:0] o_wb_data;
  int checks = 0, errors = 0, writes = 0, m_writes = 0;
  bit chk_en = 1'b0;
  bit m_act = 1'b0, m_req = 1'b0;
  int m_k = 0, m_lat = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_exp = '0;

  div_unit_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_funct3(i_funct3),
    .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val), .i_rd_addr(i_rd_addr), .i_flush(i_flush),
    .o_busy(o_busy), .o_rd_addr(o_rd_addr), .o_wb_req(o_wb_req), .o_wb_rd_addr(o_wb_rd_addr),
    .o_wb_data(o_wb_data), .i_wb_gnt(i_wb_gnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return f3[1] ? a : 32'hFFFFFFFF;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f3[1] ? 32'h0 : 32'h80000000;
    if (!f3[0]) return f3[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return f3[1] ? a % b : a / b;
  endfunction

  // reference model: one op in flight, result visible m_lat edges after the start edge
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_act = 1'b0;
      m_req = 1'b0;
    end else begin
      if (o_wb_req && i_wb_gnt) writes++;
      if (m_act) begin
        if (m_req && i_wb_gnt) begin
          m_act = 1'b0; m_req = 1'b0; m_writes++;
        end else if (i_flush) begin
          m_act = 1'b0; m_req = 1'b0;
        end else begin
          m_k++;
          m_req = m_k >= m_lat;
        end
      end else if (i_start) begin
        m_act = 1'b1; m_req = 1'b0; m_k = 0;
        m_rd  = i_rd_addr;
        m_exp = ref_res(i_funct3, i_rs1_val, i_rs2_val);
        m_lat = is_special(i_funct3, i_rs1_val, i_rs2_val) ? SL : 33;
      end
    end
  end

  always @(negedge i_clk) if (chk_en && !i_reset) begin
    chk("busy", {31'b0, o_busy}, {31'b0, m_act});
    chk("rd_addr", {27'b0, o_rd_addr}, {27'b0, m_act ? m_rd : 5'd0});
    chk("wb_req", {31'b0, o_wb_req}, {31'b0, m_req});
    if (m_req) begin
      chk("wb_rd", {27'b0, o_wb_rd_addr}, {27'b0, m_rd});
      chk("wb_data", o_wb_data, m_exp);
    end
  end

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    i_funct3 = f3; i_rs1_val = a; i_rs2_val = b; i_rd_addr = rd; i_start = 1'b1;
    @(posedge i_clk) #1;
    i_start = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!o_wb_req && lat < 100) begin
      @(posedge i_clk) #1;
      lat++;
    end
  endtask

  task automatic grant();
    i_wb_gnt = 1'b1;
    @(posedge i_clk) #1;
    i_wb_gnt = 1'b0;
  endtask

  task automatic do_op(input string n, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(f3, a, b, rd);
    chk({n, "_rd_busy"}, {27'b0, o_rd_addr}, {27'b0, rd});
    wait_req(lat);
    chk({n, "_lat"}, lat, exp_lat);
    chk({n, "_data"}, o_wb_data, exp);
    chk({n, "_wbrd"}, {27'b0, o_wb_rd_addr}, {27'b0, rd});
    grant();
    chk({n, "_idle"}, {31'b0, o_busy}, 32'd0);
    chk({n, "_rd0"}, {27'b0, o_rd_addr}, 32'd0);
  endtask

  initial begin
    int lat, w0;
    logic [2:0] f3;
    logic [31:0] a, b;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_req", {31'b0, o_wb_req}, 32'd0);
    chk("rst_data", o_wb_data, 32'd0);
    chk("rst_rd", {27'b0, o_rd_addr}, 32'd0);
    i_reset = 1'b0;
    chk_en  = 1'b1;
    chk("model_divu", ref_res(3'b101, 32'd100, 32'd7), 32'd14);
    chk("model_rem", ref_res(3'b110, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    chk("model_div", ref_res(3'b100, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);

    do_op("divu", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    do_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33);
    do_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFD, 33);
    do_op("ovf_div", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, SL);
    do_op("ovf_rem", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h0, SL);
    do_op("divu0", 3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, SL);
    do_op("remu0", 3'b111, 32'd5, 32'd0, 5'd9, 32'd5, SL);
    do_op("rem0s", 3'b110, 32'hFFFFFFF9, 32'd0, 5'd1, 32'hFFFFFFF9, SL);
    do_op("divu_big", 3'b101, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd0, 32'd0, 33);
    do_op("remu_big", 3'b111, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33);

    start_op(3'b100, 32'd1000, 32'd3, 5'd9);
    repeat (10) @(posedge i_clk) #1;
    i_flush = 1'b1;
    @(posedge i_clk) #1;
    i_flush = 1'b0;
    chk("flush_busy", {31'b0, o_busy}, 32'd0);
    chk("flush_req", {31'b0, o_wb_req}, 32'd0);
    repeat (2) @(posedge i_clk) #1;
    do_op("after_flush", 3'b101, 32'd1000, 32'd3, 5'd9, 32'd333, 33);

    start_op(3'b111, 32'd1000, 32'd7, 5'd12);
    wait_req(lat);
    chk("hold_lat", lat, 33);
    for (int i = 0; i < 5; i++) begin
      i_start = 1'b1; i_funct3 = 3'b100; i_rs1_val = $urandom; i_rs2_val = $urandom; i_rd_addr = 5'd3;
      @(posedge i_clk) #1;
      chk("hold_req", {31'b0, o_wb_req}, 32'd1);
      chk("hold_data", o_wb_data, 32'd6);
      chk("hold_rd", {27'b0, o_wb_rd_addr}, 32'd12);
    end
    i_start = 1'b0;
    w0 = writes;
    grant();
    repeat (3) @(posedge i_clk) #1;
    chk("hold_writes", writes - w0, 32'd1);
    chk("hold_idle", {31'b0, o_busy}, 32'd0);

    start_op(3'b100, 32'd12345, 32'hFFFFFFFB, 5'd3);
    repeat (5) @(posedge i_clk) #1;
    #1 i_reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, o_busy}, 32'd0);
    chk("arst_rd", {27'b0, o_rd_addr}, 32'd0);
    chk("arst_req", {31'b0, o_wb_req}, 32'd0);
    chk("arst_data", o_wb_data, 32'd0);
    #1 i_reset = 1'b0;
    @(posedge i_clk) #1;
    do_op("after_rst", 3'b100, 32'd12345, 32'hFFFFFFFB, 5'd3, 32'hFFFFF65B, 33);

    for (int t = 0; t < 60; t++) begin
      int n;
      f3 = 3'(4 + $urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 9); end
        3: begin a = $urandom; b = 32'hFFFFFFFF - $urandom_range(0, 3); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      i_flush = $urandom_range(0, 3) == 0;
      start_op(f3, a, b, 5'($urandom));
      i_flush = 1'b0;
      n = 0;
      while (o_busy && n < 80) begin
        i_flush   = $urandom_range(0, 49) == 0;
        i_wb_gnt  = o_wb_req && $urandom_range(0, 2) == 0;
        i_start   = $urandom_range(0, 5) == 0;
        i_rs1_val = $urandom; i_rs2_val = $urandom; i_rd_addr = 5'($urandom);
        @(posedge i_clk) #1;
        n++;
      end
      i_flush = 1'b0; i_wb_gnt = 1'b0; i_start = 1'b0;
      chk("rand_done", {31'b0, o_busy}, 32'd0);
      @(posedge i_clk) #1;
    end
    chk("write_count", writes, m_writes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
